gpp_demux: RTL and testbench
============================

# gpp_demux

Return-path demultiplexer between the general packet processor (GPP) and the two downstream consumers: the transmit path (tx) and the host/parser path (host). Accepts one 134-bit flit stream from GPP, buffers whole packets, and steers each complete packet by a destination field in its head flit. Packets marked invalid or carrying a reserved destination are discarded. Per-output packet counters and a drop counter are exported for status.

## Interface
- DFIFO_AW, 9: data FIFO address width (depth 512 flits)
- ALF_THRESH, 256: data FIFO occupancy at or above which input almost-full asserts
- VFIFO_ALF, 48: valid FIFO occupancy (depth 64) at or above which input almost-full asserts
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- gpp2demux_data_wr  in  1  flit write strobe
- gpp2demux_data  in  134  flit; [133:132] 01=head, 11=middle, 10=tail; head [127:126] = destination
- gpp2demux_data_valid  in  1  packet-good flag
- gpp2demux_data_valid_wr  in  1  strobe for valid flag, coincident with or after tail flit
- demux2gpp_data_alf  out  1  input almost-full
- demux2tx_data_wr / demux2tx_data[133:0] / demux2tx_data_valid / demux2tx_data_valid_wr  out  tx-side stream (same format)
- tx2demux_data_alf  in  1  tx almost-full
- demux2host_data_wr / demux2host_data[133:0] / demux2host_data_valid / demux2host_data_valid_wr  out  host-side stream
- host2demux_data_alf  in  1  host almost-full
- tx_pkt_cnt, host_pkt_cnt, drop_pkt_cnt  out  32 each  status counters

## Operation
- Internal FIFOs: data FIFO 134x512, valid FIFO 1x64, both first-word-fall-through (dout shows oldest entry while non-empty; rd_en pops).
- demux2gpp_data_alf = (data count >= ALF_THRESH) | (valid count >= VFIFO_ALF), combinational.
- Valid FIFO non-empty means a whole packet is in the data FIFO; a packet is never started earlier.
- Destination decode from head flit [127:126]: 00 -> tx, 01 -> host, 1x -> drop. Valid flag 0 -> drop regardless of destination.
- States: IDLE, TRANS_TX, TRANS_HOST, DROP. Reset -> IDLE.
- IDLE: if valid FIFO non-empty: drop condition -> DROP; dest tx and tx2demux_data_alf=0 -> TRANS_TX; dest host and host2demux_data_alf=0 -> TRANS_HOST; otherwise stay (head-of-line blocking, no reordering). No pops in IDLE.
- TRANS_x: data FIFO rd_en=1 every cycle; popped flit registered to that output with wr=1. On tail pop: valid FIFO popped in same cycle, output valid=vfifo dout, valid_wr=1 with tail flit, counter +1, -> IDLE.
- DROP: pop one flit/cycle, nothing emitted; on tail pop: pop valid FIFO, drop_pkt_cnt +1, -> IDLE.
- Downstream alf sampled only in IDLE; mid-packet alf is ignored (downstream threshold leaves room for a full 1518-byte packet, 95 flits).
- Counters 32-bit, wrap 0xFFFFFFFF -> 0.
- Malformed stream (missing tail, head-only packet) is unsupported; minimum packet two flits.

## Timing
- Reset: all *_wr, *_valid, *_valid_wr = 0; data outputs = 0; counters = 0; FIFOs empty; alf = 0.
- Outputs registered; when not writing, data = 0 and strobes = 0.
- Latency: valid FIFO non-empty at cycle t (IDLE, downstream ready) -> state change at t+1 edge -> first pop at t+1 -> head flit on output at t+2.
- Throughput: one flit/cycle during a packet; exactly one IDLE cycle between packets.
- Simultaneous GPP write and internal pop: both occur; counts update by net change.
- Reset mid-packet: FIFOs flushed, state IDLE, partial packet lost, no further output strobes.

## Test plan
- 4-flit packet, dest 00, valid 1 -> demux2tx_data_wr high 4 consecutive cycles starting 2 cycles after valid written; valid_wr=1, valid=1 with tail; tx_pkt_cnt=1; host outputs stay 0.
- Alternating dest 00/01 packets of 6 flits, back-to-back -> each emitted on correct port, in order, 1 idle cycle between; tx_pkt_cnt=host_pkt_cnt=N/2.
- Packet with valid 0 (dest 01) and packet with dest 10 -> no output strobes; drop_pkt_cnt=2; following dest-01 packet delivered intact.
- host2demux_data_alf held 1 with dest-01 packet queued, then a dest-00 packet behind it -> nothing emitted (HOL block); release alf -> host packet then tx packet.
- Fill with 260 flits while both outputs alf=1 -> demux2gpp_data_alf=1 at count 256; drain -> deasserts below 256; no flit lost.
- Assert rst_n low mid TRANS_TX -> all outputs 0 next cycle, counters 0; fresh packet after reset delivered correctly.

Source files
------------

// File: rtl/gpp_demux.sv
// Return-path demultiplexer: buffers whole GPP packets and steers each one to
// the tx or host stream by its head-flit destination, or discards it.
module gpp_demux #(
    parameter int DFIFO_AW   = 9,
    parameter int ALF_THRESH = 256,
    parameter int VFIFO_ALF  = 48
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         gpp2demux_data_wr,
    input  logic [133:0] gpp2demux_data,
    input  logic         gpp2demux_data_valid,
    input  logic         gpp2demux_data_valid_wr,
    output logic         demux2gpp_data_alf,

    output logic         demux2tx_data_wr,
    output logic [133:0] demux2tx_data,
    output logic         demux2tx_data_valid,
    output logic         demux2tx_data_valid_wr,
    input  logic         tx2demux_data_alf,

    output logic         demux2host_data_wr,
    output logic [133:0] demux2host_data,
    output logic         demux2host_data_valid,
    output logic         demux2host_data_valid_wr,
    input  logic         host2demux_data_alf,

    output logic [31:0]  tx_pkt_cnt,
    output logic [31:0]  host_pkt_cnt,
    output logic [31:0]  drop_pkt_cnt
);

    // state      | meaning
    // IDLE       | waiting for a complete packet and a ready destination
    // TRANS_TX   | streaming the head packet to the tx port
    // TRANS_HOST | streaming the head packet to the host port
    // DROP       | popping the head packet without emitting it
    typedef enum logic [1:0] {IDLE, TRANS_TX, TRANS_HOST, DROP} state_t;

    localparam int VFIFO_AW = 6;

    state_t state, state_nxt;

    logic [133:0]        dmem [2**DFIFO_AW];
    logic [DFIFO_AW-1:0] d_wptr, d_rptr;
    logic [DFIFO_AW:0]   d_cnt;
    logic                d_wr_en, d_rd_en, d_full, d_nempty;
    logic [133:0]        d_dout;

    logic                vmem [2**VFIFO_AW];
    logic [VFIFO_AW-1:0] v_wptr, v_rptr;
    logic [VFIFO_AW:0]   v_cnt;
    logic                v_wr_en, v_rd_en, v_full, v_nempty;
    logic                v_dout;

    logic [1:0]          head_dest;
    logic                is_tail;

    // Count reaches exactly the depth only when full, so its MSB is the full flag.
    assign d_full   = d_cnt[DFIFO_AW];
    assign d_nempty = (d_cnt != '0);
    assign d_dout   = dmem[d_rptr];
    assign d_wr_en  = gpp2demux_data_wr & ~d_full;

    assign v_full   = v_cnt[VFIFO_AW];
    assign v_nempty = (v_cnt != '0);
    assign v_dout   = vmem[v_rptr];
    assign v_wr_en  = gpp2demux_data_valid_wr & ~v_full;

    assign head_dest = d_dout[127:126];
    assign is_tail   = (d_dout[133:132] == 2'b10);

    assign demux2gpp_data_alf = (d_cnt >= (DFIFO_AW+1)'(ALF_THRESH)) |
                                (v_cnt >= (VFIFO_AW+1)'(VFIFO_ALF));

    always_ff @(posedge clk) begin
        if (d_wr_en) dmem[d_wptr] <= gpp2demux_data;
        if (v_wr_en) vmem[v_wptr] <= gpp2demux_data_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_wptr <= '0;
            d_rptr <= '0;
            d_cnt  <= '0;
            v_wptr <= '0;
            v_rptr <= '0;
            v_cnt  <= '0;
        end else begin
            if (d_wr_en) d_wptr <= d_wptr + 1'b1;
            if (d_rd_en) d_rptr <= d_rptr + 1'b1;
            case ({d_wr_en, d_rd_en})
                2'b10:   d_cnt <= d_cnt + 1'b1;
                2'b01:   d_cnt <= d_cnt - 1'b1;
                default: d_cnt <= d_cnt;
            endcase
            if (v_wr_en) v_wptr <= v_wptr + 1'b1;
            if (v_rd_en) v_rptr <= v_rptr + 1'b1;
            case ({v_wr_en, v_rd_en})
                2'b10:   v_cnt <= v_cnt + 1'b1;
                2'b01:   v_cnt <= v_cnt - 1'b1;
                default: v_cnt <= v_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Downstream almost-full is honoured only at packet start; the head packet
    // blocks everything behind it until its port is ready.
    always_comb begin
        state_nxt = state;
        d_rd_en   = 1'b0;
        v_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (v_nempty) begin
                    if (!v_dout || head_dest[1])
                        state_nxt = DROP;
                    else if (head_dest == 2'b00 && !tx2demux_data_alf)
                        state_nxt = TRANS_TX;
                    else if (head_dest == 2'b01 && !host2demux_data_alf)
                        state_nxt = TRANS_HOST;
                end
            end
            TRANS_TX, TRANS_HOST, DROP: begin
                d_rd_en = d_nempty;
                if (d_nempty && is_tail) begin
                    v_rd_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demux2tx_data_wr         <= 1'b0;
            demux2tx_data            <= '0;
            demux2tx_data_valid      <= 1'b0;
            demux2tx_data_valid_wr   <= 1'b0;
            demux2host_data_wr       <= 1'b0;
            demux2host_data          <= '0;
            demux2host_data_valid    <= 1'b0;
            demux2host_data_valid_wr <= 1'b0;
            tx_pkt_cnt               <= '0;
            host_pkt_cnt             <= '0;
            drop_pkt_cnt             <= '0;
        end else begin
            demux2tx_data_wr         <= (state == TRANS_TX) && d_rd_en;
            demux2tx_data            <= ((state == TRANS_TX) && d_rd_en) ? d_dout : '0;
            demux2tx_data_valid_wr   <= (state == TRANS_TX) && v_rd_en;
            demux2tx_data_valid      <= (state == TRANS_TX) && v_rd_en && v_dout;
            demux2host_data_wr       <= (state == TRANS_HOST) && d_rd_en;
            demux2host_data          <= ((state == TRANS_HOST) && d_rd_en) ? d_dout : '0;
            demux2host_data_valid_wr <= (state == TRANS_HOST) && v_rd_en;
            demux2host_data_valid    <= (state == TRANS_HOST) && v_rd_en && v_dout;
            if (v_rd_en) begin
                case (state)
                    TRANS_TX:   tx_pkt_cnt   <= tx_pkt_cnt + 32'd1;
                    TRANS_HOST: host_pkt_cnt <= host_pkt_cnt + 32'd1;
                    DROP:       drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpp_demux.sv
// Directed bench for gpp_demux: hand-built packets, captured output streams
// compared against expected flit queues, cycle positions and counters.
module tb_gpp_demux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         gpp2demux_data_wr;
    logic [133:0] gpp2demux_data;
    logic         gpp2demux_data_valid;
    logic         gpp2demux_data_valid_wr;
    logic         demux2gpp_data_alf;
    logic         demux2tx_data_wr;
    logic [133:0] demux2tx_data;
    logic         demux2tx_data_valid;
    logic         demux2tx_data_valid_wr;
    logic         tx2demux_data_alf;
    logic         demux2host_data_wr;
    logic [133:0] demux2host_data;
    logic         demux2host_data_valid;
    logic         demux2host_data_valid_wr;
    logic         host2demux_data_alf;
    logic [31:0]  tx_pkt_cnt, host_pkt_cnt, drop_pkt_cnt;

    gpp_demux dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .gpp2demux_data_wr        (gpp2demux_data_wr),
        .gpp2demux_data           (gpp2demux_data),
        .gpp2demux_data_valid     (gpp2demux_data_valid),
        .gpp2demux_data_valid_wr  (gpp2demux_data_valid_wr),
        .demux2gpp_data_alf       (demux2gpp_data_alf),
        .demux2tx_data_wr         (demux2tx_data_wr),
        .demux2tx_data            (demux2tx_data),
        .demux2tx_data_valid      (demux2tx_data_valid),
        .demux2tx_data_valid_wr   (demux2tx_data_valid_wr),
        .tx2demux_data_alf        (tx2demux_data_alf),
        .demux2host_data_wr       (demux2host_data_wr),
        .demux2host_data          (demux2host_data),
        .demux2host_data_valid    (demux2host_data_valid),
        .demux2host_data_valid_wr (demux2host_data_valid_wr),
        .host2demux_data_alf      (host2demux_data_alf),
        .tx_pkt_cnt               (tx_pkt_cnt),
        .host_pkt_cnt             (host_pkt_cnt),
        .drop_pkt_cnt             (drop_pkt_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0, anomalies = 0, seq = 1, tc = 0;
    logic [133:0] tx_q[$], host_q[$], exp_tx[$], exp_host[$];
    int           tx_cyc[$], host_cyc[$], tx_vcyc[$], host_vcyc[$];
    logic         tx_vq[$], host_vq[$];

    // Output capture just after each rising edge; idle outputs must be all-zero.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (demux2tx_data_wr) begin
            tx_q.push_back(demux2tx_data);
            tx_cyc.push_back(cyc);
        end else if (demux2tx_data !== '0 || demux2tx_data_valid_wr !== 1'b0 || demux2tx_data_valid !== 1'b0)
            anomalies++;
        if (demux2tx_data_valid_wr) begin
            tx_vq.push_back(demux2tx_data_valid);
            tx_vcyc.push_back(cyc);
        end
        if (demux2host_data_wr) begin
            host_q.push_back(demux2host_data);
            host_cyc.push_back(cyc);
        end else if (demux2host_data !== '0 || demux2host_data_valid_wr !== 1'b0 || demux2host_data_valid !== 1'b0)
            anomalies++;
        if (demux2host_data_valid_wr) begin
            host_vq.push_back(demux2host_data_valid);
            host_vcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] mk(input logic [1:0] typ, input logic [1:0] dest, input int s);
        logic [133:0] f;
        f = '0;
        f[133:132] = typ;
        f[127:126] = dest;
        f[95:64]   = ~s;
        f[31:0]    = s;
        return f;
    endfunction

    task automatic idle_inputs();
        gpp2demux_data_wr       = 1'b0;
        gpp2demux_data          = '0;
        gpp2demux_data_valid    = 1'b0;
        gpp2demux_data_valid_wr = 1'b0;
    endtask

    // Drives one packet starting at the current falling edge; port 0=tx, 1=host, 2=dropped.
    task automatic send_pkt(input logic [1:0] dest, input int n, input logic v, input int port, output int tail_cyc);
        tail_cyc = 0;
        for (int i = 0; i < n; i++) begin
            logic [133:0] f;
            f = mk((i == 0) ? 2'b01 : ((i == n-1) ? 2'b10 : 2'b11), dest, seq);
            seq++;
            gpp2demux_data_wr       = 1'b1;
            gpp2demux_data          = f;
            gpp2demux_data_valid_wr = (i == n-1);
            gpp2demux_data_valid    = (i == n-1) ? v : 1'b0;
            if (port == 0) exp_tx.push_back(f);
            else if (port == 1) exp_host.push_back(f);
            if (i == n-1) tail_cyc = cyc;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic wait_out(input int max);
        for (int i = 0; i < max; i++) begin
            if (tx_q.size() >= exp_tx.size() && host_q.size() >= exp_host.size()) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic clear_q();
        tx_q.delete(); host_q.delete(); exp_tx.delete(); exp_host.delete();
        tx_cyc.delete(); host_cyc.delete(); tx_vcyc.delete(); host_vcyc.delete();
        tx_vq.delete(); host_vq.delete();
    endtask

    task automatic check_streams(input string tag);
        chk_int({tag, "_tx_len"}, tx_q.size(), exp_tx.size());
        chk_int({tag, "_host_len"}, host_q.size(), exp_host.size());
        for (int i = 0; i < exp_tx.size(); i++)   chk({tag, "_tx_flit"}, tx_q[i], exp_tx[i]);
        for (int i = 0; i < exp_host.size(); i++) chk({tag, "_host_flit"}, host_q[i], exp_host[i]);
        clear_q();
    endtask

    initial begin
        int k;
        idle_inputs();
        tx2demux_data_alf   = 1'b0;
        host2demux_data_alf = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk_int("rst_tx_wr", demux2tx_data_wr, 0);
        chk_int("rst_host_wr", demux2host_data_wr, 0);
        chk("rst_tx_data", demux2tx_data, '0);
        chk("rst_host_data", demux2host_data, '0);
        chk_int("rst_alf", demux2gpp_data_alf, 0);
        chk_int("rst_cnts", tx_pkt_cnt | host_pkt_cnt | drop_pkt_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single 4-flit tx packet: latency, contiguity, tail-aligned valid
        send_pkt(2'b00, 4, 1'b1, 0, tc);
        wait_out(40);
        chk_int("t1_first_cyc", tx_cyc[0], tc + 3);
        chk_int("t1_contiguous", tx_cyc[3] - tx_cyc[0], 3);
        chk_int("t1_vwr_count", tx_vq.size(), 1);
        chk_int("t1_valid", tx_vq[0], 1);
        chk_int("t1_vwr_on_tail", tx_vcyc[0], tx_cyc[3]);
        chk_int("t1_tx_cnt", tx_pkt_cnt, 1);
        chk_int("t1_host_cnt", host_pkt_cnt, 0);
        check_streams("t1");

        // alternating 6-flit packets back to back: one idle cycle between packets
        for (int p = 0; p < 4; p++) send_pkt((p % 2 == 0) ? 2'b00 : 2'b01, 6, 1'b1, p % 2, tc);
        wait_out(100);
        chk_int("t2_host_contig", host_cyc[5] - host_cyc[0], 5);
        chk_int("t2_gap_a", host_cyc[0], tx_cyc[5] + 2);
        chk_int("t2_gap_b", tx_cyc[6], host_cyc[5] + 2);
        chk_int("t2_gap_c", host_cyc[6], tx_cyc[11] + 2);
        chk_int("t2_tx_cnt", tx_pkt_cnt, 3);
        chk_int("t2_host_cnt", host_pkt_cnt, 2);
        check_streams("t2");

        // invalid packet and reserved destination are dropped
        send_pkt(2'b01, 4, 1'b0, 2, tc);
        send_pkt(2'b10, 3, 1'b1, 2, tc);
        send_pkt(2'b01, 5, 1'b1, 1, tc);
        wait_out(60);
        chk_int("t3_drop_cnt", drop_pkt_cnt, 2);
        chk_int("t3_host_cnt", host_pkt_cnt, 3);
        chk_int("t3_tx_cnt", tx_pkt_cnt, 3);
        check_streams("t3");

        // head-of-line blocking behind a stalled host port
        host2demux_data_alf = 1'b1;
        send_pkt(2'b01, 4, 1'b1, 1, tc);
        send_pkt(2'b00, 4, 1'b1, 0, tc);
        repeat (30) @(negedge clk);
        chk_int("t4_blocked_tx", tx_q.size(), 0);
        chk_int("t4_blocked_host", host_q.size(), 0);
        host2demux_data_alf = 1'b0;
        wait_out(60);
        chk_int("t4_order", int'(host_cyc[3] < tx_cyc[0]), 1);
        chk_int("t4_tx_cnt", tx_pkt_cnt, 4);
        chk_int("t4_host_cnt", host_pkt_cnt, 4);
        check_streams("t4");

        // fill to the data almost-full threshold with both outputs stalled
        tx2demux_data_alf   = 1'b1;
        host2demux_data_alf = 1'b1;
        k = 0;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 26; i++) begin
                logic [133:0] f;
                if (k == 255) chk_int("t5_alf_at_255", demux2gpp_data_alf, 0);
                if (k == 256) chk_int("t5_alf_at_256", demux2gpp_data_alf, 1);
                f = mk((i == 0) ? 2'b01 : ((i == 25) ? 2'b10 : 2'b11), (p % 2 == 0) ? 2'b00 : 2'b01, seq);
                seq++;
                gpp2demux_data_wr       = 1'b1;
                gpp2demux_data          = f;
                gpp2demux_data_valid_wr = (i == 25);
                gpp2demux_data_valid    = (i == 25);
                if (p % 2 == 0) exp_tx.push_back(f); else exp_host.push_back(f);
                k++;
                @(negedge clk);
            end
        end
        idle_inputs();
        @(negedge clk);
        chk_int("t5_alf_at_260", demux2gpp_data_alf, 1);
        chk_int("t5_stalled", tx_q.size() + host_q.size(), 0);
        tx2demux_data_alf   = 1'b0;
        host2demux_data_alf = 1'b0;
        for (int i = 0; i < 20 && demux2gpp_data_alf; i++) @(negedge clk);
        chk_int("t5_alf_release_pops", tx_q.size() + host_q.size(), 5);
        wait_out(400);
        chk_int("t5_tx_cnt", tx_pkt_cnt, 9);
        chk_int("t5_host_cnt", host_pkt_cnt, 9);
        check_streams("t5");

        // reset in the middle of a tx packet
        send_pkt(2'b00, 20, 1'b1, 0, tc);
        for (int i = 0; i < 60 && tx_q.size() < 3; i++) @(negedge clk);
        chk_int("t6_mid_packet", int'(tx_q.size() >= 3), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_int("t6_rst_tx_wr", demux2tx_data_wr, 0);
        chk("t6_rst_tx_data", demux2tx_data, '0);
        chk_int("t6_rst_tx_vwr", demux2tx_data_valid_wr, 0);
        chk_int("t6_rst_tx_cnt", tx_pkt_cnt, 0);
        chk_int("t6_rst_host_cnt", host_pkt_cnt, 0);
        chk_int("t6_rst_drop_cnt", drop_pkt_cnt, 0);
        chk_int("t6_rst_alf", demux2gpp_data_alf, 0);
        rst_n = 1'b1;
        clear_q();
        repeat (30) @(negedge clk);
        chk_int("t6_no_residue_tx", tx_q.size(), 0);
        chk_int("t6_no_residue_host", host_q.size(), 0);
        send_pkt(2'b00, 3, 1'b1, 0, tc);
        wait_out(40);
        chk_int("t6_first_cyc", tx_cyc[0], tc + 3);
        chk_int("t6_tx_cnt", tx_pkt_cnt, 1);
        check_streams("t6");

        chk_int("idle_outputs_zero", anomalies, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
